// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel readout back end: pixel count, phase
// encoding and the multi-strobe detector used by the top level.
package pixel_readout_pkg;

  localparam int N_PIX     = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ERASE   = 3'd1,
    PH_EXPOSE  = 3'd2,
    PH_CONVERT = 3'd3,
    PH_READ    = 3'd4
  } phase_e;

  // True when two or more bits of the strobe vector are set.
  function automatic logic multi_hot(input logic [6:0] v);
    return (v & (v - 7'd1)) != 7'd0;
  endfunction

endpackage

// File: rtl/pixel_readout_if.sv
// Phase strobes, comparator inputs and readout results exchanged between the
// sensor FSM side (master) and the readout back end (slave).
interface pixel_readout_if
  import pixel_readout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             erase;
  logic             expose;
  logic             convert;
  logic             read1;
  logic             read2;
  logic             read3;
  logic             read4;
  logic [N_PIX-1:0] cmp;
  logic [CNT_W-1:0] ramp_code;
  logic [CNT_W-1:0] data_out;
  logic             data_valid;
  logic [1:0]       pix_idx;
  logic             protocol_err;

  modport master (
    output erase, expose, convert, read1, read2, read3, read4, cmp,
    input  ramp_code, data_out, data_valid, pix_idx, protocol_err
  );

  modport slave (
    input  erase, expose, convert, read1, read2, read3, read4, cmp,
    output ramp_code, data_out, data_valid, pix_idx, protocol_err
  );
endinterface

// File: rtl/pixel_readout_adc_channel.sv
// One pixel's conversion store: latches the ramp count when its comparator
// trips, or the overrange code if convert ends before it trips.
module pixel_adc_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             restart,
  input  logic             capture,
  input  logic             fill,
  input  logic             cmp,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] mem,
  output logic             done
);

  // Capture / overrange store; erase dominates every convert action.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= {CNT_W{1'b0}};
      done <= 1'b0;
    end else if (clr) begin
      mem <= {CNT_W{1'b0}};
      done <= 1'b0;
    end else if (restart) begin
      mem <= mem;
      done <= 1'b0;
    end else if (capture && cmp && !done) begin
      mem <= cnt;
      done <= 1'b1;
    end else if (fill && !done) begin
      mem <= {CNT_W{1'b1}};
      done <= 1'b1;
    end else begin
      mem <= mem;
      done <= done;
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// Responder side of the pixel sensor phase protocol: ramp counter, per-pixel
// capture channels, registered read mux and sticky protocol error.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  pixel_readout_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  phase_e           phase_r;
  phase_e           phase_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] mem_s [N_PIX];
  logic [N_PIX-1:0] done_s;
  logic [6:0]       strobes_s;
  logic [3:0]       rd_vec_s;
  logic [1:0]       rd_idx_s;
  logic             conv_q_s;
  logic             conv_rise_s;
  logic             conv_hold_s;
  logic             conv_fall_s;
  logic             rd_act_s;
  logic             rd_multi_s;

  assign strobes_s = {bus.erase, bus.convert, bus.read4, bus.read3,
                      bus.read2, bus.read1, bus.expose};
  assign rd_vec_s  = {bus.read4, bus.read3, bus.read2, bus.read1};
  // A convert masked by erase never entered CONVERT, so it does not count as held.
  assign conv_q_s    = (phase_r == PH_CONVERT);
  assign conv_rise_s = bus.convert & ~bus.erase & ~conv_q_s;
  assign conv_hold_s = bus.convert & ~bus.erase & conv_q_s;
  assign conv_fall_s = ~bus.convert & conv_q_s;
  assign rd_act_s    = ~bus.erase & ~bus.convert & (|rd_vec_s);
  assign rd_multi_s  = (rd_vec_s & (rd_vec_s - 4'd1)) != 4'd0;

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= PH_IDLE;
    end else begin
      phase_r <= phase_nx_s;
    end
  end

  // Next phase follows the highest-priority strobe.
  always_comb begin
    phase_nx_s = PH_IDLE;
    if (bus.erase) begin
      phase_nx_s = PH_ERASE;
    end else if (bus.convert) begin
      phase_nx_s = PH_CONVERT;
    end else if (|rd_vec_s) begin
      phase_nx_s = PH_READ;
    end else if (bus.expose) begin
      phase_nx_s = PH_EXPOSE;
    end else begin
      phase_nx_s = PH_IDLE;
    end
  end

  // One-hot read strobe to pixel index.
  always_comb begin
    rd_idx_s = 2'd0;
    case (rd_vec_s)
      4'b0001: rd_idx_s = 2'd0;
      4'b0010: rd_idx_s = 2'd1;
      4'b0100: rd_idx_s = 2'd2;
      4'b1000: rd_idx_s = 2'd3;
      default: rd_idx_s = 2'd0;
    endcase
  end

  // Ramp counter, saturating; also drives the ramp DAC directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.erase || conv_rise_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (conv_hold_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.ramp_code = cnt_r;

  for (genvar i = 0; i < N_PIX; i++) begin : g_ch
    pixel_adc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clr     (bus.erase),
      .restart (conv_rise_s),
      .capture (conv_hold_s),
      .fill    (conv_fall_s),
      .cmp     (bus.cmp[i]),
      .cnt     (cnt_r),
      .mem     (mem_s[i]),
      .done    (done_s[i])
    );
  end

  // Registered read port; an unconverted pixel reads as zero and invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_out   <= {CNT_W{1'b0}};
      bus.data_valid <= 1'b0;
      bus.pix_idx    <= 2'd0;
    end else if (rd_act_s && !rd_multi_s) begin
      bus.pix_idx    <= rd_idx_s;
      bus.data_out   <= done_s[rd_idx_s] ? mem_s[rd_idx_s] : {CNT_W{1'b0}};
      bus.data_valid <= done_s[rd_idx_s];
    end else begin
      bus.data_out   <= bus.data_out;
      bus.data_valid <= 1'b0;
      bus.pix_idx    <= bus.pix_idx;
    end
  end

  // Sticky error; a colliding strobe wins over the clear that erase applies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.protocol_err <= 1'b0;
    end else if (multi_hot(strobes_s)) begin
      bus.protocol_err <= 1'b1;
    end else if (bus.erase) begin
      bus.protocol_err <= 1'b0;
    end else if (rd_act_s && !done_s[rd_idx_s]) begin
      bus.protocol_err <= 1'b1;
    end else begin
      bus.protocol_err <= bus.protocol_err;
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Scoreboard bench for pixel_readout: an 8-bit instance for the main flows and
// a 4-bit instance for ramp saturation.
module tb_pixel_readout;
  import pixel_readout_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  pixel_readout_if #(.CNT_W(8)) bus8 ();
  pixel_readout_if #(.CNT_W(4)) bus4 ();

  pixel_readout #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  pixel_readout #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus8.erase = 1'b0; bus8.expose = 1'b0; bus8.convert = 1'b0; bus8.cmp = 4'd0;
    bus8.read1 = 1'b0; bus8.read2 = 1'b0; bus8.read3 = 1'b0; bus8.read4 = 1'b0;
    bus4.erase = 1'b0; bus4.expose = 1'b0; bus4.convert = 1'b0; bus4.cmp = 4'd0;
    bus4.read1 = 1'b0; bus4.read2 = 1'b0; bus4.read3 = 1'b0; bus4.read4 = 1'b0;
  endtask

  task automatic drive_read8(input logic [3:0] v);
    bus8.read1 = v[0]; bus8.read2 = v[1]; bus8.read3 = v[2]; bus8.read4 = v[3];
  endtask

  // Convert for n cycles; comparator i trips once the ramp has reached t[i].
  task automatic conv8(input int n, input int t0, input int t1, input int t2, input int t3);
    int exp_ramp;
    for (int c = 0; c < n; c++) begin
      bus8.convert = 1'b1;
      bus8.cmp[0] = (c >= 1) && ((c - 1) >= t0);
      bus8.cmp[1] = (c >= 1) && ((c - 1) >= t1);
      bus8.cmp[2] = (c >= 1) && ((c - 1) >= t2);
      bus8.cmp[3] = (c >= 1) && ((c - 1) >= t3);
      tick();
      exp_ramp = (c > 255) ? 255 : c;
      total++;
      if (bus8.ramp_code !== exp_ramp[7:0]) begin
        bad++;
        $display("FAIL ramp8 c=%0d: got %0d want %0d", c, bus8.ramp_code, exp_ramp);
      end
    end
    bus8.convert = 1'b0;
    bus8.cmp = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus8.ramp_code, bus8.data_out, bus8.data_valid, bus8.pix_idx, bus8.protocol_err} !== 20'd0) begin
      bad++;
      $display("FAIL reset8: got ramp=%0d d=%0d v=%0b i=%0d e=%0b want all 0",
               bus8.ramp_code, bus8.data_out, bus8.data_valid, bus8.pix_idx, bus8.protocol_err);
    end
    total++;
    if ({bus4.ramp_code, bus4.data_out, bus4.data_valid, bus4.protocol_err} !== 10'd0) begin
      bad++;
      $display("FAIL reset4: got ramp=%0d d=%0d want 0", bus4.ramp_code, bus4.data_out);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int thr [4] = '{5, 0, 12, 19};
    exp_t e;
    bus8.erase = 1'b1;
    repeat (2) tick();
    bus8.erase = 1'b0;
    // 21 cycles: the rising cycle plus enough held cycles to sample count 19.
    conv8(21, thr[0], thr[1], thr[2], thr[3]);
    for (int k = 0; k < 4; k++) begin
      drive_read8(4'b0001 << k);
      e.data = thr[k][7:0]; e.idx = k[1:0]; e.valid = 1'b1;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      total++;
      if (bus8.data_valid !== e.valid || bus8.data_out !== e.data || bus8.pix_idx !== e.idx) begin
        bad++;
        $display("FAIL basic_read%0d: got v=%0b d=%0d i=%0d want v=%0b d=%0d i=%0d", k + 1,
                 bus8.data_valid, bus8.data_out, bus8.pix_idx, e.valid, e.data, e.idx);
      end
    end
    drive_read8(4'd0);
    tick();
    total++;
    if (bus8.data_valid !== 1'b0 || bus8.data_out !== 8'd19 || bus8.protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: got v=%0b d=%0d e=%0b want v=0 d=19 e=0",
               bus8.data_valid, bus8.data_out, bus8.protocol_err);
    end
  endtask

  task automatic test_overrange();
    exp_t e;
    logic [3:0] rv [3] = '{4'b0001, 4'b0100, 4'b1000};
    logic [7:0] dv [3] = '{8'd2, 8'd255, 8'd4};
    logic [1:0] iv [3] = '{2'd0, 2'd2, 2'd3};
    // Restart without erase; pixel 2 never trips.
    conv8(10, 2, 3, 1000, 4);
    for (int k = 0; k < 3; k++) begin
      drive_read8(rv[k]);
      e.data = dv[k]; e.idx = iv[k]; e.valid = 1'b1;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      total++;
      if (bus8.data_valid !== e.valid || bus8.data_out !== e.data || bus8.pix_idx !== e.idx) begin
        bad++;
        $display("FAIL overrange_read%0d: got v=%0b d=%0d i=%0d want v=%0b d=%0d i=%0d", k,
                 bus8.data_valid, bus8.data_out, bus8.pix_idx, e.valid, e.data, e.idx);
      end
    end
    drive_read8(4'd0);
    tick();
  endtask

  task automatic test_read_unconverted();
    exp_t e;
    bus8.erase = 1'b1;
    repeat (2) tick();
    bus8.erase = 1'b0;
    drive_read8(4'b0010);
    e.data = 8'd0; e.idx = 2'd1; e.valid = 1'b0;
    sb.push_back(e);
    tick();
    drive_read8(4'd0);
    e = sb.pop_front();
    total++;
    if (bus8.data_valid !== e.valid || bus8.data_out !== e.data || bus8.pix_idx !== e.idx) begin
      bad++;
      $display("FAIL unconv_read: got v=%0b d=%0d i=%0d want v=%0b d=%0d i=%0d",
               bus8.data_valid, bus8.data_out, bus8.pix_idx, e.valid, e.data, e.idx);
    end
    total++;
    if (bus8.protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL unconv_err: got %0b want 1", bus8.protocol_err);
    end
    repeat (3) tick();
    total++;
    if (bus8.protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL unconv_sticky: got %0b want 1", bus8.protocol_err);
    end
    bus8.erase = 1'b1;
    tick();
    bus8.erase = 1'b0;
    total++;
    if (bus8.protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL unconv_clear: got %0b want 0", bus8.protocol_err);
    end
  endtask

  task automatic test_multi_strobe();
    exp_t e;
    drive_read8(4'b0101);
    e.data = 8'd0; e.idx = 2'd1; e.valid = 1'b0;
    sb.push_back(e);
    tick();
    drive_read8(4'd0);
    e = sb.pop_front();
    total++;
    if (bus8.data_valid !== e.valid || bus8.data_out !== e.data || bus8.pix_idx !== e.idx
        || bus8.protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL multi_read: got v=%0b d=%0d i=%0d e=%0b want v=0 d=%0d i=%0d e=1",
               bus8.data_valid, bus8.data_out, bus8.pix_idx, bus8.protocol_err, e.data, e.idx);
    end
    bus8.erase = 1'b1;
    tick();
    bus8.erase = 1'b0;
    // Run the ramp up first so an erase that loses to convert would be visible.
    bus8.convert = 1'b1;
    repeat (4) tick();
    bus8.erase = 1'b1;
    tick();
    total++;
    if (bus8.ramp_code !== 8'd0 || bus8.protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL erase_convert: got ramp=%0d e=%0b want ramp=0 e=1",
               bus8.ramp_code, bus8.protocol_err);
    end
    bus8.erase = 1'b0;
    bus8.convert = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_convert();
    bus8.convert = 1'b1;
    bus8.expose = 1'b1;
    tick();
    bus8.expose = 1'b0;
    repeat (7) tick();
    total++;
    if (bus8.ramp_code !== 8'd7 || bus8.protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got ramp=%0d e=%0b want ramp=7 e=1",
               bus8.ramp_code, bus8.protocol_err);
    end
    reset = 1'b0;
    #2;
    total++;
    if ({bus8.ramp_code, bus8.data_out, bus8.data_valid, bus8.pix_idx, bus8.protocol_err} !== 20'd0) begin
      bad++;
      $display("FAIL async_reset: got ramp=%0d d=%0d v=%0b i=%0d e=%0b want all 0",
               bus8.ramp_code, bus8.data_out, bus8.data_valid, bus8.pix_idx, bus8.protocol_err);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus8.ramp_code !== c[7:0]) begin
        bad++;
        $display("FAIL restart_ramp c=%0d: got %0d want %0d", c, bus8.ramp_code, c);
      end
    end
    bus8.convert = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    exp_t e;
    int exp_ramp;
    bus4.erase = 1'b1;
    tick();
    bus4.erase = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus4.convert = 1'b1;
      bus4.cmp[1] = (c >= 30);
      tick();
      exp_ramp = (c > 15) ? 15 : c;
      total++;
      if (bus4.ramp_code !== exp_ramp[3:0]) begin
        bad++;
        $display("FAIL ramp4 c=%0d: got %0d want %0d", c, bus4.ramp_code, exp_ramp);
      end
    end
    bus4.convert = 1'b0;
    bus4.cmp = 4'd0;
    tick();
    bus4.read2 = 1'b1;
    e.data = 8'd15; e.idx = 2'd1; e.valid = 1'b1;
    sb.push_back(e);
    tick();
    bus4.read2 = 1'b0;
    e = sb.pop_front();
    total++;
    if (bus4.data_valid !== e.valid || bus4.data_out !== e.data[3:0] || bus4.pix_idx !== e.idx) begin
      bad++;
      $display("FAIL sat_read: got v=%0b d=%0d i=%0d want v=%0b d=%0d i=%0d",
               bus4.data_valid, bus4.data_out, bus4.pix_idx, e.valid, e.data, e.idx);
    end
    total++;
    if (bus4.ramp_code !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold: got %0d want 15", bus4.ramp_code);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrange();
    test_read_unconverted();
    test_multi_strobe();
    test_reset_mid_convert();
    test_saturation();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
